pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
//
// PURPOSE
// - Pipelined successor of the single-cycle opcode decoder: decodes the ID-stage opcode and carries the
//   control bundle through ID/EX, EX/MEM and MEM/WB registers, one register set per stage.
// - Detects load-use hazards, inserts bubbles on stall/flush, flags illegal opcodes and counts stall cycles.
// - Sits between the IF/ID register and the datapath; drives per-stage control, and drives stall back to PC/IF.
//
// PARAMETERS
// - REG_AW    5   register-address width (rs1/rs2/rd)
// - ALU_OP_W  2   width of alu_op; must be >= 2 (3 when EXT_OPS_EN is defined)
// - CNT_W     16  width of the saturating stall counter
//
// PORTS
// - clk            in   1         clock, rising edge
// - rst            in   1         synchronous, active-high reset
// - id_valid       in   1         ID stage holds a real instruction
// - opcode         in   7         ID instruction [6:0]
// - rs1, rs2, rd   in   REG_AW    ID source/destination register fields
// - flush          in   1         branch taken, resolved in EX; kill the ID instruction
// - hazard_stall   out  1         combinational; hold PC and IF/ID this cycle
// - ex_valid       out  1         EX stage: valid
// - ex_alu_src     out  1         EX stage: ALU B from immediate
// - ex_alu_op      out  ALU_OP_W  EX stage: ALU op class
// - ex_branch      out  1         EX stage: branch
// - ex_illegal     out  1         EX stage: illegal opcode
// - mem_read       out  1         MEM stage: load
// - mem_write      out  1         MEM stage: store
// - wb_reg_write   out  1         WB stage: register write enable
// - wb_mem_to_reg  out  1         WB stage: writeback from memory
// - wb_rd          out  REG_AW    WB stage: destination register
// - stall_cnt      out  CNT_W     saturating count of hazard_stall cycles
//
// BEHAVIOUR
// - Decode table (combinational, ID), fields {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}:
//   - R 0110011 = 0,0,1,0,0,0,10
//   - LD 0000011 = 1,1,1,1,0,0,00
//   - ST 0100011 = 1,0,0,0,1,0,00
//   - BR 1100011 = 0,0,0,0,0,1,01
//   - Any other opcode: all fields 0; illegal=1 when id_valid=1.
// - reg_write is forced to 0 when rd == 0.
// - A bubble is: all control bits 0, valid 0, rd 0, illegal 0.
// - Latency from ID: ex_* after 1 cycle, mem_* after 2, wb_* after 3. EX->MEM->WB advance every cycle; no back-pressure.
// - Load-use hazard: hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ~flush
//   & (ex_rd == rs1 | (uses_rs2 & ex_rd == rs2)).
//   - uses_rs2 = 1 for R, ST and BR opcodes.
//   - ex_rd and ex_mem_read are held internally in the ID/EX register.
// - ID/EX load priority: rst > flush > hazard_stall > normal.
//   - flush: ID/EX loads a bubble.
//   - hazard_stall: ID/EX loads a bubble; upstream holds the instruction, so it re-presents next cycle.
//   - normal: ID/EX loads the decoded bundle gated by id_valid (id_valid=0 loads a bubble).
// - A stall resolves after one bubble, because the load then sits in MEM.
// - stall_cnt increments each cycle hazard_stall=1 and saturates at 2^CNT_W-1; it does not wrap.
// - Reset: all stage registers become bubbles and stall_cnt=0. Every output is 0 in the cycle after rst.
//   - hazard_stall is 0 during rst because ex_valid=0.
// - Reset mid-operation discards all in-flight control the same cycle; nothing from before reset retires after it.
//
// CONFIGURATION
// - Macro PIPE_CTRL_EXT_OPS_EN; ALU_OP_W must be 3 when it is defined.
// - Defined: adds decodes, all with reg_write=1 and no rs2 use:
//   - I-ALU 0010011: alu_src=1, alu_op=011
//   - LUI 0110111: alu_src=1, alu_op=100
//   - AUIPC 0010111: alu_src=1, alu_op=101
//   - JAL 1101111: branch=1, alu_op=110
//   - JALR 1100111: branch=1, alu_src=1, alu_op=110
// - Undefined: those opcodes decode as illegal bubbles, exactly like any other unknown opcode.
//
// TESTING
// - rst=1 for 2 cycles with random inputs -> every output 0 and stall_cnt=0 one cycle after rst.
// - R-type rd=5, then 3 bubbles -> ex_alu_op=10 at +1, wb_reg_write=1 and wb_rd=5 at +3, nothing else set.
// - LD rd=7, then R with rs2=7 -> hazard_stall=1 for exactly 1 cycle; EX bubble; R reaches EX 2 cycles after LD; stall_cnt=1.
// - LD rd=0, then R with rs1=0 -> no stall; wb_reg_write=0 for both instructions.
// - flush=1 while a load-use hazard is present -> hazard_stall=0; bubble in EX; stall_cnt unchanged.
// - opcode 0010011 -> ex_illegal=1 when the macro is undefined; ex_alu_src=1, alu_op=011, wb_reg_write=1 when defined.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: ID-side inputs and per-stage control outputs of pipe_ctrl_unit
interface pipe_ctrl_unit_if #(
    parameter int REG_AW = 5,
`ifdef PIPE_CTRL_EXT_OPS_EN
    parameter int ALU_OP_W = 3,
`else
    parameter int ALU_OP_W = 2,
`endif
    parameter int CNT_W = 16
);
    logic                id_valid;
    logic [6:0]          opcode;
    logic [REG_AW-1:0]   rs1, rs2, rd;
    logic                flush;
    logic                hazard_stall;
    logic                ex_valid, ex_alu_src, ex_branch, ex_illegal;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                mem_read, mem_write;
    logic                wb_reg_write, wb_mem_to_reg;
    logic [REG_AW-1:0]   wb_rd;
    logic [CNT_W-1:0]    stall_cnt;
    modport master (
        output id_valid, opcode, rs1, rs2, rd, flush,
        input  hazard_stall, ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_illegal,
        input  mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd, stall_cnt
    );
    modport slave (
        input  id_valid, opcode, rs1, rs2, rd, flush,
        output hazard_stall, ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_illegal,
        output mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID decode, ID/EX/MEM/WB control pipeline and load-use stall; PIPE_CTRL_EXT_OPS_EN adds I-ALU/LUI/AUIPC/JAL/JALR
module pipe_ctrl_unit #(
    parameter int REG_AW = 5,
`ifdef PIPE_CTRL_EXT_OPS_EN
    parameter int ALU_OP_W = 3,
`else
    parameter int ALU_OP_W = 2,
`endif
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    pipe_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, illegal;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0] rd;
    } ctrl_t;
    ctrl_t dec, id_ex;
    logic uses_rs2, stall;
    logic em_rw, em_m2r, em_mr, em_mw;
    logic [REG_AW-1:0] em_rd;
    logic mw_rw, mw_m2r;
    logic [REG_AW-1:0] mw_rd;
    logic [CNT_W-1:0] cnt;
    always_comb begin
        dec = '0;
        uses_rs2 = 1'b0;
        case (bus.opcode)
            7'b0110011: begin dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(2'b10); uses_rs2 = 1'b1; end
            7'b0000011: begin dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1; end
            7'b0100011: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; uses_rs2 = 1'b1; end
            7'b1100011: begin dec.branch = 1'b1; dec.alu_op = ALU_OP_W'(2'b01); uses_rs2 = 1'b1; end
`ifdef PIPE_CTRL_EXT_OPS_EN
            7'b0010011: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(3'b011); end
            7'b0110111: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(3'b100); end
            7'b0010111: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(3'b101); end
            7'b1101111: begin dec.branch = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(3'b110); end
            7'b1100111: begin dec.branch = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(3'b110); end
`endif
            default: dec.illegal = 1'b1;
        endcase
        dec.valid = 1'b1;
        dec.rd = bus.rd;
        dec.reg_write = dec.reg_write & (|bus.rd);
        dec = bus.id_valid ? dec : '0;
    end
    // the load's rd is only known here while it sits in EX, one cycle before its data exists
    assign stall = ~rst & bus.id_valid & id_ex.valid & id_ex.mem_read & (|id_ex.rd) & ~bus.flush
                   & (id_ex.rd == bus.rs1 | (uses_rs2 & id_ex.rd == bus.rs2));
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex <= '0;
            {em_rw, em_m2r, em_mr, em_mw, em_rd} <= '0;
            {mw_rw, mw_m2r, mw_rd} <= '0;
            cnt <= '0;
        end else begin
            id_ex <= (bus.flush | stall) ? '0 : dec;
            {em_rw, em_m2r, em_mr, em_mw, em_rd} <= {id_ex.reg_write, id_ex.mem_to_reg, id_ex.mem_read, id_ex.mem_write, id_ex.rd};
            {mw_rw, mw_m2r, mw_rd} <= {em_rw, em_m2r, em_rd};
            cnt <= (stall & ~(&cnt)) ? cnt + CNT_W'(1) : cnt;
        end
    end
    assign bus.hazard_stall  = stall;
    assign bus.ex_valid      = id_ex.valid;
    assign bus.ex_alu_src    = id_ex.alu_src;
    assign bus.ex_alu_op     = id_ex.alu_op;
    assign bus.ex_branch     = id_ex.branch;
    assign bus.ex_illegal    = id_ex.illegal;
    assign bus.mem_read      = em_mr;
    assign bus.mem_write     = em_mw;
    assign bus.wb_reg_write  = mw_rw;
    assign bus.wb_mem_to_reg = mw_m2r;
    assign bus.wb_rd         = mw_rd;
    assign bus.stall_cnt     = cnt;
endmodule
